// File: rtl/gcm_block_sequencer_if.sv
// Message-level handshakes plus the gcm_aes core-facing bus for gcm_block_sequencer.
// The master modport is the sequencer's view; slave is the environment's view.
interface gcm_block_sequencer_if #(
  parameter int NB_W = 5
);
  logic            i_start;
  logic            o_start_ready;
  logic [127:0]    i_cipher_key;
  logic [95:0]     i_iv;
  logic [127:0]    i_aad;
  logic [NB_W-1:0] i_num_blocks;
  logic            o_err;
  logic            i_pt_valid;
  logic            o_pt_ready;
  logic [127:0]    i_pt_data;
  logic            o_ct_valid;
  logic            i_ct_ready;
  logic [127:0]    o_ct_data;
  logic            o_ct_last;
  logic            o_tag_valid;
  logic            i_tag_ready;
  logic [127:0]    o_tag;
  logic            o_busy;
  logic            o_core_valid;
  logic            o_core_new_instance;
  logic [127:0]    o_core_cipher_key;
  logic [95:0]     o_core_iv;
  logic [127:0]    o_core_aad;
  logic [127:0]    o_core_plain_text;
  logic [127:0]    i_core_cipher_text;
  logic [127:0]    i_core_tag;
  logic            i_core_tag_ready;

  modport master (
    input  i_start, i_cipher_key, i_iv, i_aad, i_num_blocks,
    input  i_pt_valid, i_pt_data, i_ct_ready, i_tag_ready,
    input  i_core_cipher_text, i_core_tag, i_core_tag_ready,
    output o_start_ready, o_err, o_pt_ready, o_ct_valid, o_ct_data, o_ct_last,
    output o_tag_valid, o_tag, o_busy, o_core_valid, o_core_new_instance,
    output o_core_cipher_key, o_core_iv, o_core_aad, o_core_plain_text
  );

  modport slave (
    output i_start, i_cipher_key, i_iv, i_aad, i_num_blocks,
    output i_pt_valid, i_pt_data, i_ct_ready, i_tag_ready,
    output i_core_cipher_text, i_core_tag, i_core_tag_ready,
    input  o_start_ready, o_err, o_pt_ready, o_ct_valid, o_ct_data, o_ct_last,
    input  o_tag_valid, o_tag, o_busy, o_core_valid, o_core_new_instance,
    input  o_core_cipher_key, o_core_iv, o_core_aad, o_core_plain_text
  );
endinterface

// File: rtl/gcm_block_sequencer.sv
// Feeds one GCM message through a non-stallable core of CORE_LAT cycles, FWFT ciphertext FIFO out.
// Back-pressure is by credit: a block issues only if in-flight plus queued results leave FIFO room.
module gcm_block_sequencer #(
  parameter int CORE_LAT   = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int NB_W       = 5
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  gcm_block_sequencer_if.master bus
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_TAG_OUT = 2'd3;

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [1:0]          state;
  logic [127:0]        key_q;
  logic [95:0]         iv_q;
  logic [127:0]        aad_q;
  logic [127:0]        tag_q;
  logic [NB_W-1:0]     remaining;
  logic                first_q;
  logic                tag_held;
  logic                err_q;
  logic [CORE_LAT-1:0] sr_vld;
  logic [CORE_LAT-1:0] sr_last;
  logic [CW-1:0]       inflight;
  logic [CW-1:0]       fifo_count;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [128:0]        mem [FIFO_DEPTH];

  logic                start_acc;
  logic                issue;
  logic                last_issue;
  logic                credit;
  logic                push;
  logic                pop;
  logic                fifo_empty;
  logic                tag_cap;
  logic [CW:0]         occupancy;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign occupancy  = {1'b0, inflight} + {1'b0, fifo_count};
  assign credit     = occupancy < (CW+1)'(FIFO_DEPTH);
  assign start_acc  = bus.i_start && (state == S_IDLE);
  assign issue      = (state == S_RUN) && bus.i_pt_valid && credit;
  assign last_issue = issue && (remaining == NB_W'(1));
  assign push       = sr_vld[CORE_LAT-1];
  assign fifo_empty = (fifo_count == '0);
  assign pop        = !fifo_empty && bus.i_ct_ready;
  // The core tag is only meaningful once this message has started issuing.
  assign tag_cap    = bus.i_core_tag_ready && !tag_held && (state != S_IDLE) && (!first_q || issue);

  assign bus.o_start_ready       = (state == S_IDLE);
  assign bus.o_busy              = (state != S_IDLE);
  assign bus.o_err               = err_q;
  assign bus.o_pt_ready          = (state == S_RUN) && credit;
  assign bus.o_core_valid        = issue;
  assign bus.o_core_new_instance = issue && first_q;
  assign bus.o_core_cipher_key   = key_q;
  assign bus.o_core_iv           = iv_q;
  assign bus.o_core_aad          = aad_q;
  assign bus.o_core_plain_text   = bus.i_pt_data;
  assign bus.o_ct_valid          = !fifo_empty;
  assign bus.o_ct_data           = fifo_empty ? '0 : mem[rd_ptr][127:0];
  assign bus.o_ct_last           = !fifo_empty && mem[rd_ptr][128];
  assign bus.o_tag_valid         = (state == S_TAG_OUT);
  assign bus.o_tag               = tag_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      key_q     <= '0;
      iv_q      <= '0;
      aad_q     <= '0;
      tag_q     <= '0;
      remaining <= '0;
      first_q   <= 1'b0;
      tag_held  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= start_acc && (bus.i_num_blocks == '0);
      if (tag_cap) begin
        tag_q    <= bus.i_core_tag;
        tag_held <= 1'b1;
      end
      if (issue) begin
        remaining <= remaining - NB_W'(1);
        first_q   <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (start_acc && (bus.i_num_blocks != '0)) begin
            key_q     <= bus.i_cipher_key;
            iv_q      <= bus.i_iv;
            aad_q     <= bus.i_aad;
            remaining <= bus.i_num_blocks;
            first_q   <= 1'b1;
            tag_held  <= 1'b0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (last_issue) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if ((inflight == '0) && fifo_empty && (tag_held || tag_cap)) state <= S_TAG_OUT;
        end
        S_TAG_OUT: begin
          if (bus.i_tag_ready) begin
            tag_held <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Latency line mirrors the core pipeline; its tail marks the cycle a result is on i_core_cipher_text.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sr_vld     <= '0;
      sr_last    <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      sr_vld  <= {sr_vld[CORE_LAT-2:0], issue};
      sr_last <= {sr_last[CORE_LAT-2:0], last_issue};
      if (issue && !push)      inflight <= inflight + CW'(1);
      else if (!issue && push) inflight <= inflight - CW'(1);
      if (push && !pop)        fifo_count <= fifo_count + CW'(1);
      else if (!push && pop)   fifo_count <= fifo_count - CW'(1);
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sr_last[CORE_LAT-1], bus.i_core_cipher_text};
  end
endmodule

// File: tb/tb_gcm_block_sequencer.sv
// Scoreboard bench for gcm_block_sequencer with a behavioural fixed-latency core model.
module tb_gcm_block_sequencer;
  localparam int CORE_LAT   = 10;
  localparam int FIFO_DEPTH = 16;
  localparam int NB_W       = 5;

  localparam logic [127:0] KEY     = 128'hFEFFE9928665731C6D6A8F9467308308;
  localparam logic [95:0]  IV      = 96'hCAFEBABEFACEDBADDECAF888;
  localparam logic [127:0] AAD     = 128'hFEEDFACEDEADBEEFFEEDFACEDEADBEEF;
  localparam logic [127:0] TAG_BAD = 128'hBADBADBADBADBADBADBADBADBADBAD00;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gcm_block_sequencer_if #(.NB_W(NB_W)) bus ();

  gcm_block_sequencer #(
    .CORE_LAT(CORE_LAT), .FIFO_DEPTH(FIFO_DEPTH), .NB_W(NB_W)
  ) dut (
    .clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int n_issue = 0;
  int unsigned cyc = 0;
  logic [128:0] exp_ct [$];
  logic [127:0] exp_tag [$];
  logic [127:0] tag_hold;
  logic tag_hold_vld = 1'b0;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [127:0] pt_of(input int i);
    logic [31:0] w;
    case (i)
      0: return 128'hD9313225F88406E5A55909C5AFF5269A;
      1: return 128'h86A7A9531534F7DA2E4C303D8A318A72;
      2: return 128'h1C3C0C95956809532FCF0E2449A6B525;
      3: return 128'hB16AEDF5AA0DE657BA637B391AAFD255;
      default: begin
        w = 32'(i) * 32'h9E3779B9;
        return {w, ~w, w ^ 32'h5A5A5A5A, 32'(i)};
      end
    endcase
  endfunction

  function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] k,
                                           input logic [95:0] iv, input logic [127:0] aad,
                                           input int idx);
    return pt ^ k ^ aad ^ {iv, 32'(idx)};
  endfunction

  // Behavioural core: fixed CORE_LAT pipeline, block index restarts on new_instance.
  logic [CORE_LAT-1:0] cm_vld = '0;
  logic [127:0] cm_dat [CORE_LAT];
  int cm_idx = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_core_valid) cm_idx = bus.o_core_new_instance ? 0 : cm_idx + 1;
    cm_vld    <= {cm_vld[CORE_LAT-2:0], bus.o_core_valid};
    cm_dat[0] <= core_fn(bus.o_core_plain_text, bus.o_core_cipher_key, bus.o_core_iv,
                         bus.o_core_aad, cm_idx);
    for (int k = 1; k < CORE_LAT; k++) cm_dat[k] <= cm_dat[k-1];
  end
  assign bus.i_core_cipher_text = cm_vld[CORE_LAT-1] ? cm_dat[CORE_LAT-1] : 128'hDEADDEADDEADDEADDEADDEADDEADDEAD;

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      tag_hold_vld = 1'b0;
    end else begin
      if (bus.o_core_valid) n_issue++;
      if (bus.o_ct_valid && bus.i_ct_ready) begin
        if (exp_ct.size() == 0) begin
          chk("ct_unexpected", bus.o_ct_data, '0);
          chk("ct_unexpected_valid", bus.o_ct_valid, 1'b0);
        end else begin
          logic [128:0] e;
          e = exp_ct.pop_front();
          chk("ct_data", bus.o_ct_data, e[127:0]);
          chk("ct_last", bus.o_ct_last, e[128]);
        end
      end
      if (bus.o_tag_valid) begin
        chk("tag_after_ct", exp_ct.size(), 0);
        if (tag_hold_vld) chk("tag_stable", bus.o_tag, tag_hold);
        if (bus.i_tag_ready) begin
          tag_hold_vld = 1'b0;
          if (exp_tag.size() == 0) chk("tag_unexpected", bus.o_tag_valid, 1'b0);
          else chk("tag_value", bus.o_tag, exp_tag.pop_front());
        end else begin
          tag_hold     = bus.o_tag;
          tag_hold_vld = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_msg(input int nb);
    bus.i_start      = 1'b1;
    bus.i_num_blocks = NB_W'(nb);
    bus.i_cipher_key = KEY;
    bus.i_iv         = IV;
    bus.i_aad        = AAD;
    @(negedge clk);
    chk("start_ready_idle", bus.o_start_ready, 1'b1);
    tick();
    bus.i_start      = 1'b0;
    bus.i_cipher_key = {$urandom, $urandom, $urandom, $urandom};
    bus.i_iv         = {$urandom, $urandom, $urandom};
    bus.i_aad        = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    chk("busy_after_start", bus.o_busy, 1'b1);
    chk("start_ready_busy", bus.o_start_ready, 1'b0);
    tick();
  endtask

  task automatic send_blocks(input int n, input int nb);
    int t;
    for (int i = 0; i < n; i++) begin
      bus.i_pt_valid = 1'b1;
      bus.i_pt_data  = pt_of(i);
      t = 0;
      @(negedge clk);
      while (!bus.o_pt_ready && t < 400) begin
        t++;
        @(negedge clk);
      end
      chk("pt_ready_wait", bus.o_pt_ready, 1'b1);
      if (!bus.o_pt_ready) break;
      chk("core_valid", bus.o_core_valid, 1'b1);
      chk("new_instance", bus.o_core_new_instance, i == 0);
      chk("core_pt", bus.o_core_plain_text, pt_of(i));
      chk("core_key", bus.o_core_cipher_key, KEY);
      exp_ct.push_back({i == nb - 1, core_fn(pt_of(i), KEY, IV, AAD, i)});
      tick();
    end
    bus.i_pt_valid = 1'b0;
    bus.i_pt_data  = '0;
  endtask

  task automatic pulse_tag(input logic [127:0] v, input bit expected);
    bus.i_core_tag_ready = 1'b1;
    bus.i_core_tag       = v;
    if (expected) exp_tag.push_back(v);
    tick();
    bus.i_core_tag_ready = 1'b0;
    bus.i_core_tag       = '0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (bus.o_busy && t < 400) begin
      t++;
      @(negedge clk);
    end
    chk("return_idle", bus.o_start_ready, 1'b1);
    chk("ct_drained", exp_ct.size(), 0);
    chk("tag_drained", exp_tag.size(), 0);
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start_ready"}, bus.o_start_ready, 1'b1);
    chk({tag, "_busy"}, bus.o_busy, 1'b0);
    chk({tag, "_pt_ready"}, bus.o_pt_ready, 1'b0);
    chk({tag, "_ct_valid"}, bus.o_ct_valid, 1'b0);
    chk({tag, "_tag_valid"}, bus.o_tag_valid, 1'b0);
    chk({tag, "_tag"}, bus.o_tag, '0);
    chk({tag, "_err"}, bus.o_err, 1'b0);
    chk({tag, "_core_valid"}, bus.o_core_valid, 1'b0);
    chk({tag, "_core_key"}, bus.o_core_cipher_key, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int unsigned c0;
    int t;
    bit sb_done;
    bus.i_start = 1'b0; bus.i_cipher_key = '0; bus.i_iv = '0; bus.i_aad = '0;
    bus.i_num_blocks = '0; bus.i_pt_valid = 1'b0; bus.i_pt_data = '0;
    bus.i_ct_ready = 1'b0; bus.i_tag_ready = 1'b0;
    bus.i_core_tag = '0; bus.i_core_tag_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // Four-block message, all ready; early tag strobe before any issue is ignored
    bus.i_ct_ready = 1'b1; bus.i_tag_ready = 1'b1;
    start_msg(4);
    pulse_tag(TAG_BAD, 1'b0);
    c0 = cyc;
    send_blocks(4, 4);
    chk("four_back_to_back", cyc - c0, 4);
    pulse_tag(128'h4D5C2AF327CD64A62CF35ABD2BA6FAB4, 1'b1);
    pulse_tag(TAG_BAD, 1'b0);
    wait_idle();
    chk("busy_low_after_tag", bus.o_busy, 1'b0);

    // Zero-block start is rejected with a single err pulse
    base = n_issue;
    bus.i_start = 1'b1; bus.i_num_blocks = '0;
    tick();
    bus.i_start = 1'b0;
    @(negedge clk);
    chk("err_pulse", bus.o_err, 1'b1);
    chk("err_start_ready", bus.o_start_ready, 1'b1);
    chk("err_busy", bus.o_busy, 1'b0);
    tick();
    @(negedge clk);
    chk("err_one_cycle", bus.o_err, 1'b0);
    chk("err_no_issue", n_issue - base, 0);
    tick();

    // Credit back-pressure: 20 blocks offered with ct_ready low
    bus.i_ct_ready = 1'b0;
    start_msg(20);
    base = n_issue;
    sb_done = 1'b0;
    fork
      begin
        send_blocks(20, 20);
        sb_done = 1'b1;
      end
    join_none
    repeat (40) @(negedge clk);
    #1;
    chk("credit_16_issues", n_issue - base, 16);
    chk("credit_pt_ready_low", bus.o_pt_ready, 1'b0);
    @(posedge clk);
    #1;
    bus.i_ct_ready = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("credit_one_per_pop", n_issue - base, 20);
    pulse_tag(128'h0123456789ABCDEF0F1E2D3C4B5A6978, 1'b1);
    t = 0;
    while (!sb_done && t < 500) begin t++; tick(); end
    chk("credit_send_done", sb_done, 1'b1);
    wait_idle();

    // Tag arrives before the last pops; tag_ready held low for 5 cycles
    bus.i_ct_ready = 1'b0; bus.i_tag_ready = 1'b0;
    start_msg(4);
    send_blocks(4, 4);
    repeat (12) tick();
    chk("fifo_holding", bus.o_ct_valid, 1'b1);
    chk("no_tag_yet", bus.o_tag_valid, 1'b0);
    pulse_tag(128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_1357, 1'b1);
    tick();
    bus.i_ct_ready = 1'b1;
    pulse_tag(TAG_BAD, 1'b0);
    t = 0;
    @(negedge clk);
    while (!bus.o_tag_valid && t < 50) begin t++; @(negedge clk); end
    chk("tag_valid_seen", bus.o_tag_valid, 1'b1);
    chk("ct_empty_at_tag", bus.o_ct_valid, 1'b0);
    tick();
    repeat (5) tick();
    chk("tag_still_valid", bus.o_tag_valid, 1'b1);
    bus.i_tag_ready = 1'b1;
    wait_idle();

    // Reset two cycles after the second issue of a four-block message
    start_msg(4);
    send_blocks(2, 4);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    exp_ct.delete();
    exp_tag.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    start_msg(1);
    send_blocks(1, 1);
    pulse_tag(128'h1111222233334444555566667777AAAA, 1'b1);
    wait_idle();

    // 31 blocks: fill, then steady push/pop with pointer wrap
    bus.i_ct_ready = 1'b0;
    start_msg(31);
    sb_done = 1'b0;
    fork
      begin
        send_blocks(31, 31);
        sb_done = 1'b1;
      end
    join_none
    repeat (30) tick();
    chk("wrap_full_no_ready", bus.o_pt_ready, 1'b0);
    bus.i_ct_ready = 1'b1;
    repeat (5) tick();
    pulse_tag(128'hC0FFEE00C0FFEE00C0FFEE00C0FFEE31, 1'b1);
    t = 0;
    while (!sb_done && t < 500) begin t++; tick(); end
    chk("wrap_send_done", sb_done, 1'b1);
    wait_idle();

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
